// File: rtl/add_subtract_itself_core.sv
// rtl/add_subtract_itself_core.sv - registered-operand add/subtract accumulator with carry and overflow flags
module add_subtract_itself_core (
    input  logic       i_clk,
    input  logic       ni_rst,
    input  logic [7:0] i_a,
    input  logic       add_sub,
    output logic [7:0] o_sum,
    output logic       o_carry,
    output logic       o_ovf
);

    logic signed [7:0] o_a;
    logic signed [7:0] o_result;

    logic [7:0] operand_b;
    logic [8:0] raw_sum;
    logic [7:0] next_result;
    logic       next_ovf;

    // One shared adder: subtract is the inverted accumulator plus a carry-in of one,
    // so the carry-out reads as "no borrow" when subtracting.
    always_comb begin
        operand_b   = add_sub ? ~o_result : o_result;
        raw_sum     = {1'b0, o_a} + {1'b0, operand_b} + {8'd0, add_sub};
        next_result = raw_sum[7:0];
        next_ovf    = (o_a[7] == operand_b[7]) && (next_result[7] != o_a[7]);
    end

    // Operand capture, accumulate and flag update; flags describe only the latest edge.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            o_a      <= '0;
            o_result <= '0;
            o_carry  <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            o_a      <= i_a;
            o_result <= next_result;
            o_carry  <= raw_sum[8];
            o_ovf    <= next_ovf;
        end
    end

    assign o_sum = o_result;

endmodule

// File: tb/tb_add_subtract_itself_core.sv
// tb/tb_add_subtract_itself_core.sv - directed self-checking bench for add_subtract_itself_core
module tb_add_subtract_itself_core;

    logic       i_clk;
    logic       ni_rst;
    logic [7:0] i_a;
    logic       add_sub;
    logic [7:0] o_sum;
    logic       o_carry;
    logic       o_ovf;

    int errors = 0;
    int checks = 0;

    add_subtract_itself_core dut (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_a     (i_a),
        .add_sub (add_sub),
        .o_sum   (o_sum),
        .o_carry (o_carry),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input integer exp);
        check(tag, integer'($signed(o_sum)), exp);
    endtask

    task automatic chk_flags(input string tag, input integer c, input integer v);
        check({tag, "_carry"}, integer'(o_carry), c);
        check({tag, "_ovf"}, integer'(o_ovf), v);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        ni_rst = 1'b0;
        tick();
        ni_rst = 1'b1;
    endtask

    initial begin
        ni_rst  = 1'b0;
        i_a     = 8'd0;
        add_sub = 1'b0;
        #2;
        chk_sum("reset_sum", 0);
        chk_flags("reset", 0, 0);
        check("reset_o_a", integer'($signed(dut.o_a)), 0);
        check("reset_o_result", integer'($signed(dut.o_result)), 0);
        tick();
        ni_rst = 1'b1;

        // Add chain
        add_sub = 1'b0;
        i_a = 8'd17;  tick(); chk_sum("add1", 0);
        i_a = 8'd75;  tick(); chk_sum("add2", 17);   check("add2_ovf", integer'(o_ovf), 0);
        i_a = -8'sd63; tick(); chk_sum("add3", 92);  check("add3_ovf", integer'(o_ovf), 0);
        i_a = -8'sd36; tick(); chk_sum("add4", 29);  chk_flags("add4", 1, 0);
        i_a = 8'd0;   tick(); chk_sum("add5", -7);   chk_flags("add5", 0, 0);

        // Positive overflow
        do_reset();
        add_sub = 1'b0;
        i_a = 8'd93;
        tick(); chk_sum("pov1", 0);
        tick(); chk_sum("pov2", 93);
        tick(); chk_sum("pov3", -70); chk_flags("pov3", 0, 1);
        tick(); chk_sum("pov4", 23);  chk_flags("pov4", 1, 0);

        // Asynchronous reset mid-cycle with a nonzero accumulator
        #2;
        ni_rst = 1'b0;
        #1;
        chk_sum("arst_sum", 0);
        chk_flags("arst", 0, 0);
        check("arst_o_a", integer'($signed(dut.o_a)), 0);
        tick();
        chk_sum("arst_hold_sum", 0);
        check("arst_hold_o_a", integer'($signed(dut.o_a)), 0);
        ni_rst = 1'b1;

        // Negative overflow
        add_sub = 1'b0;
        i_a = -8'sd37;
        tick(); chk_sum("nov1", 0);
        tick(); chk_sum("nov2", -37);
        tick(); chk_sum("nov3", -74);
        tick(); chk_sum("nov4", -111); check("nov4_ovf", integer'(o_ovf), 0);
        tick(); chk_sum("nov5", 108);  chk_flags("nov5", 1, 1);

        // Subtract chain
        do_reset();
        add_sub = 1'b1;
        i_a = -8'sd36; tick(); chk_sum("sub1", 0);   chk_flags("sub1", 1, 0);
        i_a = -8'sd63; tick(); chk_sum("sub2", -36); chk_flags("sub2", 1, 0);
        i_a = -8'sd10; tick(); chk_sum("sub3", -27); chk_flags("sub3", 0, 0);
        i_a = 8'd120;  tick(); chk_sum("sub4", 17);  check("sub4_ovf", integer'(o_ovf), 0);
        i_a = 8'd57;   tick(); chk_sum("sub5", 103); check("sub5_ovf", integer'(o_ovf), 0);
        i_a = -8'sd46; tick(); chk_sum("sub6", -46); check("sub6_ovf", integer'(o_ovf), 0);
        i_a = 8'd0;    tick(); chk_sum("sub7", 0);   check("sub7_ovf", integer'(o_ovf), 0);

        // Subtract overflow after switching add_sub with no flush
        do_reset();
        add_sub = 1'b0;
        i_a = -8'sd63; tick(); chk_sum("sov1", 0);
        i_a = 8'd75;   tick(); chk_sum("sov2", -63);
        check("sov2_o_a", integer'($signed(dut.o_a)), 75);
        add_sub = 1'b1;
        tick(); chk_sum("sov3", -118); chk_flags("sov3", 0, 1);
        tick(); chk_sum("sov4", -63);  chk_flags("sov4", 0, 1);
        add_sub = 1'b0;
        tick(); chk_sum("sov5", 12);   chk_flags("sov5", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_subtract_itself_core.md
ADD_SUBTRACT_ITSELF_CORE -- requirements
Module: add_subtract_itself

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port ni_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_a, input, 8 bits, signed two's complement: operand sample.
REQ-004 SHALL have port add_sub, input, 1 bit: operation select, 0 = add, 1 = subtract.
REQ-005 SHALL have port o_sum, output, 8 bits, signed: accumulated result.
REQ-006 SHALL have port o_carry, output, 1 bit: carry-out flag of the last accumulate operation.
REQ-007 SHALL have port o_ovf, output, 1 bit: signed-overflow flag of the last accumulate operation.
REQ-008 SHALL contain internal 8-bit signed registers named o_a (registered operand) and o_result (accumulator), reachable hierarchically by name.

Function
REQ-009 SHALL load o_a <= i_a on every rising i_clk edge while ni_rst=1.
REQ-010 SHALL, on the same edge, load o_result <= o_a + o_result when add_sub=0, or o_a - o_result when add_sub=1; add_sub is sampled at that edge.
REQ-011 SHALL drive o_sum combinationally from o_result.
REQ-012 SHALL give 2-cycle latency: an i_a value captured at edge k contributes to o_sum after edge k+1.
REQ-013 SHALL compute in 8-bit two's complement with wrap-around; no saturation; the accumulator keeps the wrapped value after overflow.
REQ-014 SHALL implement subtract as o_a + ~o_result + 1.
REQ-015 SHALL register o_carry, on the same edge as o_result, as bit 8 of the 9-bit unsigned sum actually formed; for subtract, 1 = no borrow.
REQ-016 SHALL register o_ovf, on the same edge as o_result, as 1 when both adder operands (o_a and the possibly inverted o_result) have equal sign bits and the result sign differs; else 0.
REQ-017 SHALL make flags non-sticky; each edge overwrites them for the latest operation only.
REQ-018 SHALL apply a change of add_sub between edges to the next accumulate only, with no flush of o_a or o_result.

Reset
REQ-019 SHALL, when ni_rst=0, immediately (asynchronously) clear o_a, o_result, o_carry and o_ovf to 0, so o_sum=0.
REQ-020 SHALL hold all registers at 0 while ni_rst=0, including reset asserted mid-cycle, and resume with REQ-009/010 on the first rising edge after ni_rst returns to 1.

Verification
REQ-021 Add chain: reset, add_sub=0, i_a = 17, 75, -63, -36, 0 one per cycle -> o_sum = 0, 17, 92, 29, -7 on successive edges, no o_ovf.
REQ-022 Positive overflow: reset, add_sub=0, i_a=93 held -> o_sum = 0, 93, -70 (o_ovf=1, o_carry=0), then 23 (o_ovf=0, o_carry=1).
REQ-023 Negative overflow: reset, add_sub=0, i_a=-37 held -> o_sum = -37, -74, -111, then 108 with o_ovf=1, o_carry=1.
REQ-024 Subtract chain: reset, add_sub=1, i_a = -36, -63, -10, 120, 57, -46 -> o_sum = -36, -27, 17, 103, -46, 0; no o_ovf.
REQ-025 Subtract overflow: accumulator = -63, o_a = 75, add_sub=1 -> o_sum = -118, o_ovf=1; next 75 -> -63, o_ovf=1.
REQ-026 Async reset: drop ni_rst mid-cycle with nonzero accumulator -> o_sum, o_carry and o_ovf = 0 before the next clock edge.
